// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares a single uarttx byte transmitter between NUM_REQ message sources. A source raises
// req while it has a message pending; the scheduler grants one source at a time, in
// round-robin order, and keeps the grant for the whole message. The grant is released only
// after the byte flagged by src_last has been sent.
//
// For every byte the scheduler:
//   1. latches the owner's byte onto txdata;
//   2. pulses wrsig and the owner's byte_ack together for one clock;
//   3. waits for tx_busy to rise, giving up after BUSY_TO clocks;
//   4. waits for tx_busy to fall;
//   5. idles for GAP_CYCLES clocks before the next byte or the release.
//
// All outputs are registered. The whole block runs on the divided UART clock.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   GAP_CYCLES  idle clocks enforced after tx_busy falls (>= 1)
//   BUSY_TO     clocks to wait for tx_busy to rise after wrsig (>= 1)
//
// Ports
//   clk       in   UART clock, all logic on posedge
//   reset     in   synchronous, active-high
//   req       in   [NUM_REQ]   per-source message pending, sampled only while idle
//   src_data  in   [8*NUM_REQ] current byte of source i at [8*i+7:8*i]
//   src_last  in   [NUM_REQ]   source i's current byte is its final byte
//   byte_ack  out  [NUM_REQ]   one-clock pulse: source i's byte was taken
//   grant     out  [NUM_REQ]   one-hot owner of the transmitter, 0 when idle
//   txdata    out  [8]         byte presented to uarttx
//   wrsig     out  1           one-clock write strobe to uarttx
//   tx_busy   in   1           uarttx is shifting a frame
//   active    out  1           scheduler is not idle
// ---------------------------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned BUSY_TO    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] src_data,
    input  logic [NUM_REQ-1:0]   src_last,
    output logic [NUM_REQ-1:0]   byte_ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           txdata,
    output logic                 wrsig,
    input  logic                 tx_busy,
    output logic                 active
);

    localparam int unsigned IdxW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BusyCntW = $clog2(BUSY_TO + 1);
    localparam int unsigned GapCntW  = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitBusy,
        StWaitDone,
        StGap,
        StRelease
    } state_e;

    state_e                state_q,    state_d;
    logic [IdxW-1:0]       owner_q,    owner_d;
    logic [IdxW-1:0]       ptr_q,      ptr_d;
    logic                  last_q,     last_d;
    logic [BusyCntW-1:0]   busy_cnt_q, busy_cnt_d;
    logic [GapCntW-1:0]    gap_cnt_q,  gap_cnt_d;
    logic [NUM_REQ-1:0]    grant_q,    grant_d;
    logic [NUM_REQ-1:0]    byte_ack_q, byte_ack_d;
    logic [7:0]            txdata_q,   txdata_d;
    logic                  wrsig_q,    wrsig_d;
    logic                  active_q,   active_d;

    // Round-robin pick: first requester at or after the pointer, wrapping to source 0.
    logic                  pick_valid;
    logic [IdxW-1:0]       pick_idx;
    int unsigned           cand;
    logic [IdxW-1:0]       cand_idx;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand     = (32'(ptr_q) + i) % NUM_REQ;
            cand_idx = IdxW'(cand);
            if (!pick_valid && req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Byte and last flag of the current owner; only consumed in StLoad.
    logic [7:0]            owner_byte;
    logic                  owner_last;

    always_comb begin
        owner_byte = 8'h00;
        owner_last = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IdxW'(i) == owner_q) begin
                owner_byte = src_data[8*i +: 8];
                owner_last = src_last[i];
            end
        end
    end

    logic [NUM_REQ-1:0]    pick_onehot;
    logic [NUM_REQ-1:0]    owner_onehot;
    logic [IdxW-1:0]       ptr_after_owner;

    always_comb begin
        pick_onehot     = NUM_REQ'(1) << pick_idx;
        owner_onehot    = NUM_REQ'(1) << owner_q;
        ptr_after_owner = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        last_d     = last_q;
        busy_cnt_d = busy_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        grant_d    = grant_q;
        txdata_d   = txdata_q;
        byte_ack_d = '0;
        wrsig_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // tx_busy is deliberately ignored here; only a new request moves us on.
                if (pick_valid) begin
                    owner_d = pick_idx;
                    grant_d = pick_onehot;
                    state_d = StLoad;
                end
            end

            StLoad: begin
                txdata_d   = owner_byte;
                last_d     = owner_last;
                byte_ack_d = owner_onehot;
                wrsig_d    = 1'b1;
                busy_cnt_d = '0;
                state_d    = StWaitBusy;
            end

            StWaitBusy: begin
                // A transmitter that never raises busy must not stall the message.
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (busy_cnt_q == BusyCntW'(BUSY_TO - 1)) begin
                    state_d = StWaitDone;
                end else begin
                    busy_cnt_d = busy_cnt_q + 1'b1;
                end
            end

            StWaitDone: begin
                if (!tx_busy) begin
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end
            end

            StGap: begin
                if (gap_cnt_q == GapCntW'(GAP_CYCLES - 1)) begin
                    state_d = last_q ? StRelease : StLoad;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            StRelease: begin
                grant_d = '0;
                ptr_d   = ptr_after_owner;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase

        active_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            ptr_q      <= '0;
            last_q     <= 1'b0;
            busy_cnt_q <= '0;
            gap_cnt_q  <= '0;
            grant_q    <= '0;
            byte_ack_q <= '0;
            txdata_q   <= 8'h00;
            wrsig_q    <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            last_q     <= last_d;
            busy_cnt_q <= busy_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            grant_q    <= grant_d;
            byte_ack_q <= byte_ack_d;
            txdata_q   <= txdata_d;
            wrsig_q    <= wrsig_d;
            active_q   <= active_d;
        end
    end

    assign grant    = grant_q;
    assign byte_ack = byte_ack_q;
    assign txdata   = txdata_q;
    assign wrsig    = wrsig_q;
    assign active   = active_q;

endmodule
